// File: rtl/operands_if.sv
// Operand-pair bus between the FPU issue logic and the binary32 operand parser.
// The master drives the operand pair and the slave returns the registered field decode.
interface operands_if;
    logic        valid_i;
    logic [31:0] x_i;
    logic [31:0] y_i;
    logic        valid_o;
    logic        x_sign_o;
    logic        y_sign_o;
    logic [7:0]  x_exp_o;
    logic [7:0]  y_exp_o;
    logic [22:0] x_frac_o;
    logic [22:0] y_frac_o;
    logic        x_greater_o;
    logic [7:0]  exp_shift_o;
    logic        x_infinity_o;
    logic        y_infinity_o;
    logic        x_nan_o;
    logic        y_nan_o;

    modport master (
        output valid_i, x_i, y_i,
        input  valid_o, x_sign_o, y_sign_o, x_exp_o, y_exp_o, x_frac_o, y_frac_o,
               x_greater_o, exp_shift_o, x_infinity_o, y_infinity_o, x_nan_o, y_nan_o
    );

    modport slave (
        input  valid_i, x_i, y_i,
        output valid_o, x_sign_o, y_sign_o, x_exp_o, y_exp_o, x_frac_o, y_frac_o,
               x_greater_o, exp_shift_o, x_infinity_o, y_infinity_o, x_nan_o, y_nan_o
    );
endinterface

// File: rtl/operands.sv
// binary32 operand parser: splits two operands into fields, compares exponents and
// flags inf/NaN, registered with one-cycle latency for the add/sub alignment stage.
module operands (
    input  logic       clk_i,
    input  logic       rst_i,
    operands_if.slave  bus
);
    logic        valid_d,     valid_q;
    logic        x_sign_d,    x_sign_q;
    logic        y_sign_d,    y_sign_q;
    logic [7:0]  x_exp_d,     x_exp_q;
    logic [7:0]  y_exp_d,     y_exp_q;
    logic [22:0] x_frac_d,    x_frac_q;
    logic [22:0] y_frac_d,    y_frac_q;
    logic        x_greater_d, x_greater_q;
    logic [7:0]  exp_shift_d, exp_shift_q;
    logic        x_inf_d,     x_inf_q;
    logic        y_inf_d,     y_inf_q;
    logic        x_nan_d,     x_nan_q;
    logic        y_nan_d,     y_nan_q;

    logic [7:0]  x_exp_in;
    logic [7:0]  y_exp_in;
    logic        x_gt_in;

    assign x_exp_in = bus.x_i[30:23];
    assign y_exp_in = bus.y_i[30:23];
    assign x_gt_in  = x_exp_in > y_exp_in;

    always_comb begin
        valid_d     = bus.valid_i;
        x_sign_d    = x_sign_q;
        y_sign_d    = y_sign_q;
        x_exp_d     = x_exp_q;
        y_exp_d     = y_exp_q;
        x_frac_d    = x_frac_q;
        y_frac_d    = y_frac_q;
        x_greater_d = x_greater_q;
        exp_shift_d = exp_shift_q;
        x_inf_d     = x_inf_q;
        y_inf_d     = y_inf_q;
        x_nan_d     = x_nan_q;
        y_nan_d     = y_nan_q;
        if (bus.valid_i) begin
            x_sign_d    = bus.x_i[31];
            y_sign_d    = bus.y_i[31];
            x_exp_d     = x_exp_in;
            y_exp_d     = y_exp_in;
            x_frac_d    = bus.x_i[22:0];
            y_frac_d    = bus.y_i[22:0];
            x_greater_d = x_gt_in;
            // Larger minus smaller never wraps, so the magnitude always fits in 8 bits.
            exp_shift_d = x_gt_in ? (x_exp_in - y_exp_in) : (y_exp_in - x_exp_in);
            x_inf_d     = (x_exp_in == 8'hff) && (bus.x_i[22:0] == 23'd0);
            y_inf_d     = (y_exp_in == 8'hff) && (bus.y_i[22:0] == 23'd0);
            x_nan_d     = (x_exp_in == 8'hff) && (bus.x_i[22:0] != 23'd0);
            y_nan_d     = (y_exp_in == 8'hff) && (bus.y_i[22:0] != 23'd0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= 1'b0;
            x_sign_q    <= 1'b0;
            y_sign_q    <= 1'b0;
            x_exp_q     <= 8'd0;
            y_exp_q     <= 8'd0;
            x_frac_q    <= 23'd0;
            y_frac_q    <= 23'd0;
            x_greater_q <= 1'b0;
            exp_shift_q <= 8'd0;
            x_inf_q     <= 1'b0;
            y_inf_q     <= 1'b0;
            x_nan_q     <= 1'b0;
            y_nan_q     <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            x_sign_q    <= x_sign_d;
            y_sign_q    <= y_sign_d;
            x_exp_q     <= x_exp_d;
            y_exp_q     <= y_exp_d;
            x_frac_q    <= x_frac_d;
            y_frac_q    <= y_frac_d;
            x_greater_q <= x_greater_d;
            exp_shift_q <= exp_shift_d;
            x_inf_q     <= x_inf_d;
            y_inf_q     <= y_inf_d;
            x_nan_q     <= x_nan_d;
            y_nan_q     <= y_nan_d;
        end
    end

    assign bus.valid_o      = valid_q;
    assign bus.x_sign_o     = x_sign_q;
    assign bus.y_sign_o     = y_sign_q;
    assign bus.x_exp_o      = x_exp_q;
    assign bus.y_exp_o      = y_exp_q;
    assign bus.x_frac_o     = x_frac_q;
    assign bus.y_frac_o     = y_frac_q;
    assign bus.x_greater_o  = x_greater_q;
    assign bus.exp_shift_o  = exp_shift_q;
    assign bus.x_infinity_o = x_inf_q;
    assign bus.y_infinity_o = y_inf_q;
    assign bus.x_nan_o      = x_nan_q;
    assign bus.y_nan_o      = y_nan_q;
endmodule

// File: tb/tb_operands.sv
// Directed table-driven bench for the binary32 operand parser: reset, single pairs,
// back-to-back issue, hold on idle and reset priority over a concurrent pair.
module tb_operands;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    operands_if bus ();

    operands dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [31:0] x;
        logic [31:0] y;
        logic        sx;
        logic        sy;
        logic [7:0]  ex;
        logic [7:0]  ey;
        logic [22:0] fx;
        logic [22:0] fy;
        logic        gt;
        logic [7:0]  sh;
        logic        xi;
        logic        yi;
        logic        xn;
        logic        yn;
    } vec_t;

    // {valid, sx, sy, ex, ey, fx, fy, gt, sh, xi, yi, xn, yn}
    typedef logic [77:0] obs_t;

    vec_t vecs[6];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic obs_t expect_of(input vec_t v, input logic valid);
        return {valid, v.sx, v.sy, v.ex, v.ey, v.fx, v.fy, v.gt, v.sh, v.xi, v.yi, v.xn, v.yn};
    endfunction

    function automatic obs_t observed();
        return {bus.valid_o, bus.x_sign_o, bus.y_sign_o, bus.x_exp_o, bus.y_exp_o,
                bus.x_frac_o, bus.y_frac_o, bus.x_greater_o, bus.exp_shift_o,
                bus.x_infinity_o, bus.y_infinity_o, bus.x_nan_o, bus.y_nan_o};
    endfunction

    task automatic check(input string name, input obs_t exp_v);
        obs_t act;
        act = observed();
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y);
        bus.valid_i = v;
        bus.x_i     = x;
        bus.y_i     = y;
    endtask

    initial begin
        vecs[0] = '{"normal",  32'h3fc00000, 32'h4500001a, 1'b0, 1'b0, 8'h7f, 8'h8a,
                    23'h400000, 23'h00001a, 1'b0, 8'h0b, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{"inf",     32'h7f800000, 32'hbaa3d70a, 1'b0, 1'b1, 8'hff, 8'h75,
                    23'h000000, 23'h23d70a, 1'b1, 8'h8a, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{"nan",     32'h7fffffff, 32'hc0c28f5c, 1'b0, 1'b1, 8'hff, 8'h81,
                    23'h7fffff, 23'h428f5c, 1'b1, 8'h7e, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{"mirror",  32'h37f9fb03, 32'h7fffffff, 1'b0, 1'b0, 8'h6f, 8'hff,
                    23'h79fb03, 23'h7fffff, 1'b0, 8'h90, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{"zeros",   32'h00000000, 32'h80000000, 1'b0, 1'b1, 8'h00, 8'h00,
                    23'h000000, 23'h000000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{"inf_zero", 32'h7f800000, 32'h00000000, 1'b0, 1'b0, 8'hff, 8'h00,
                    23'h000000, 23'h000000, 1'b1, 8'hff, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset held for two cycles with a pair presented.
        rst_i = 1'b1;
        drive(1'b1, 32'h7f800000, 32'h00000000);
        step();
        step();
        check("reset_hold", '0);

        // Pair presented in the same cycle as reset must be dropped.
        rst_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step();
        rst_i = 1'b1;
        drive(1'b1, 32'h7f800000, 32'h00000000);
        step();
        check("reset_discard", '0);
        rst_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step();
        check("idle_after_reset", '0);

        // Isolated pairs, each followed by an idle cycle.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vecs[i].x, vecs[i].y);
            step();
            check({"single_", vecs[i].name}, expect_of(vecs[i], 1'b1));
            drive(1'b0, 32'h12345678, 32'hffffffff);
            step();
            check({"idle_", vecs[i].name}, expect_of(vecs[i], 1'b0));
        end

        // Back-to-back: each result exactly one edge after its pair, never earlier.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vecs[i].x, vecs[i].y);
            #1;
            if (i > 0) check({"no_comb_", vecs[i].name}, expect_of(vecs[i-1], 1'b1));
            step();
            check({"b2b_", vecs[i].name}, expect_of(vecs[i], 1'b1));
        end

        // Drop valid: data holds last pair even though inputs change.
        drive(1'b0, 32'h3fc00000, 32'h4500001a);
        step();
        check("hold_valid_low", expect_of(vecs[5], 1'b0));
        step();
        check("hold_second_cycle", expect_of(vecs[5], 1'b0));

        // Reset wins over a concurrent valid pair after live data.
        drive(1'b1, vecs[2].x, vecs[2].y);
        step();
        check("pre_reset_nan", expect_of(vecs[2], 1'b1));
        rst_i = 1'b1;
        drive(1'b1, vecs[1].x, vecs[1].y);
        step();
        check("reset_clears_data", '0);
        rst_i = 1'b0;
        step();
        check("post_reset_capture", expect_of(vecs[1], 1'b1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/operands.md
Name: operands

Overview:
- Front-end operand parser for the single-precision (IEEE-754 binary32) FPU datapath.
- Splits two 32-bit operands into sign, exponent and fraction fields.
- Compares the exponents, produces the absolute exponent difference used for alignment, and flags infinity/NaN.
- All outputs are registered, with one-cycle latency, and feed the add/sub alignment stage.

Parameters:
- None. Format is fixed at binary32: 1 sign bit, 8 exponent bits, 23 fraction bits.

Ports:
- clk_i         input   1   system clock; all state updates on rising edge
- rst_i         input   1   synchronous, active-high reset
- valid_i       input   1   x_i/y_i hold a new operand pair this cycle
- x_i           input   32  operand X, binary32
- y_i           input   32  operand Y, binary32
- valid_o       output  1   outputs below correspond to the pair accepted on the previous cycle
- x_sign_o      output  1   X bit 31
- y_sign_o      output  1   Y bit 31
- x_exp_o       output  8   X bits 30:23, biased, unmodified
- y_exp_o       output  8   Y bits 30:23
- x_frac_o      output  23  X bits 22:0; no hidden bit
- y_frac_o      output  23  Y bits 22:0
- x_greater_o   output  1   1 iff x_exp > y_exp, unsigned strict
- exp_shift_o   output  8   |x_exp − y_exp|
- x_infinity_o  output  1   X exp == 8'hFF and frac == 0
- y_infinity_o  output  1   Y exp == 8'hFF and frac == 0
- x_nan_o       output  1   X exp == 8'hFF and frac != 0
- y_nan_o       output  1   Y exp == 8'hFF and frac != 0

Behaviour:
- Reset:
  - When rst_i is high at a rising edge, every output register clears to 0, including valid_o.
  - Reset takes priority over valid_i.
  - A pair presented in the same cycle as reset is discarded.
- Capture:
  - At a rising edge with rst_i=0 and valid_i=1, all outputs update from x_i/y_i.
  - valid_o is set to 1 at that edge.
- Hold:
  - At a rising edge with rst_i=0 and valid_i=0, data outputs hold their last values.
  - valid_o goes to 0 at that edge.
- Latency and throughput:
  - Latency is exactly 1 cycle.
  - Throughput is one pair per cycle; no backpressure.
- Field extraction: a pure bit slice. Sign is passed through unchanged for zeros, infinities and NaNs (−0.0 gives sign 1).
- Exponent compare:
  - Unsigned 8-bit compare.
  - Equal exponents give x_greater_o=0 and exp_shift_o=0.
  - Difference is always taken as larger minus smaller, so there is no wrap-around.
  - Range is 0..255 and always fits in 8 bits.
- Special-value flags:
  - Decoded per operand, independently of the other operand and of sign.
  - infinity and nan are mutually exclusive per operand.
  - Exponent 0 (zero/denormal) raises no flag.
  - No special-case override of exp_shift_o or x_greater_o: ff vs any exponent is computed numerically.
- Combinational decode from x_i/y_i feeds the registers. No output depends combinationally on inputs within the same cycle.

Test Plan:
- Reset: hold rst_i=1 for 2 cycles with valid_i=1 and x_i=7f800000 -> all outputs 0 including valid_o. Then repeat the pair with rst_i=1 asserted in the capture cycle -> pair discarded, outputs remain 0.
- Normal pair: x=3fc00000 (1.5), y=4500001a (2048.0063), valid_i=1 -> next cycle:
  - signs 0/0, exps 7f/8a, fracs 400000/00001a
  - x_greater_o=0, exp_shift_o=0b, all flags 0, valid_o=1
- Infinity: x=7f800000, y=baa3d70a ->
  - x_infinity_o=1, x_nan_o=0, y flags 0
  - y_sign_o=1, exps ff/75, fracs 000000/23d70a
  - x_greater_o=1, exp_shift_o=8a
- NaN: x=7fffffff, y=c0c28f5c ->
  - x_nan_o=1, x_frac_o=7fffff, y_sign_o=1, y_exp_o=81
  - x_greater_o=1, exp_shift_o=7e
- Mirror: x=37f9fb03, y=7fffffff -> y_nan_o=1, x_exp_o=6f, x_greater_o=0, exp_shift_o=90.
- Signed zeros: x=00000000, y=80000000 -> y_sign_o=1, everything else 0, x_greater_o=0, exp_shift_o=0.
- Back-to-back and hold:
  - Apply the six pairs above on consecutive cycles -> each result appears exactly one cycle later.
  - Then drop valid_i -> valid_o=0 next cycle, data holds the last pair.
